// File: rtl/instruction_fetch_unit.sv
// PC and instruction-fetch stage of the 8-bit CPU.
// Fetches one word over a busywait handshake, then holds it until retire.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDRESS,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSYWAIT,
    output logic [31:0] PC,
    output logic [31:0] INSTRUCTION,
    output logic        INSTR_VALID,
    input  logic        EXEC_BUSY,
    input  logic        JUMP,
    input  logic        BRANCH,
    input  logic        ZERO,
    input  logic [7:0]  OFFSET,
    output logic [31:0] INSTR_COUNT
);

    typedef enum logic {
        S_FETCH,
        S_EXEC
    } state_t;

    state_t      state;
    logic [31:0] pc4;
    logic [31:0] next_pc;
    logic        taken;

    // OFFSET counts words, so it is sign-extended and scaled by 4
    always_comb begin
        pc4     = PC + 32'd4;
        taken   = JUMP | (BRANCH & ZERO);
        next_pc = pc4;
        if (taken)
            next_pc = pc4 + {{22{OFFSET[7]}}, OFFSET, 2'b00};
    end

    assign IMEM_READ    = (state == S_FETCH) & ~RESET;
    assign IMEM_ADDRESS = PC;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= S_FETCH;
            PC          <= RESET_PC;
            INSTRUCTION <= 32'd0;
            INSTR_VALID <= 1'b0;
            INSTR_COUNT <= 32'd0;
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (!IMEM_BUSYWAIT) begin
                        INSTRUCTION <= IMEM_READDATA;
                        INSTR_VALID <= 1'b1;
                        state       <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!EXEC_BUSY) begin
                        PC          <= next_pc;
                        INSTR_COUNT <= INSTR_COUNT + 32'd1;
                        INSTR_VALID <= 1'b0;
                        state       <= S_FETCH;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit.
// Fetched words are predicted into a scoreboard and popped on INSTR_VALID rise.
module tb_instruction_fetch_unit;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        IMEM_READ;
    logic [31:0] IMEM_ADDRESS;
    logic [31:0] IMEM_READDATA;
    logic        IMEM_BUSYWAIT = 1'b0;
    logic [31:0] PC;
    logic [31:0] INSTRUCTION;
    logic        INSTR_VALID;
    logic        EXEC_BUSY = 1'b0;
    logic        JUMP = 1'b0;
    logic        BRANCH = 1'b0;
    logic        ZERO = 1'b0;
    logic [7:0]  OFFSET = 8'h00;
    logic [31:0] INSTR_COUNT;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] exp_cnt = 32'h0;
    logic [31:0] exp_instr = 32'h0;
    logic        prev_valid = 1'b0;

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .IMEM_READ(IMEM_READ),
        .IMEM_ADDRESS(IMEM_ADDRESS),
        .IMEM_READDATA(IMEM_READDATA),
        .IMEM_BUSYWAIT(IMEM_BUSYWAIT),
        .PC(PC),
        .INSTRUCTION(INSTRUCTION),
        .INSTR_VALID(INSTR_VALID),
        .EXEC_BUSY(EXEC_BUSY),
        .JUMP(JUMP),
        .BRANCH(BRANCH),
        .ZERO(ZERO),
        .OFFSET(OFFSET),
        .INSTR_COUNT(INSTR_COUNT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h1111_1111;
            32'h4:   return 32'h2222_2222;
            32'h8:   return 32'h3333_3333;
            default: return a ^ 32'hC0DE_0000;
        endcase
    endfunction

    assign IMEM_READDATA = mem(IMEM_ADDRESS);

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // scoreboard consumer: every new valid instruction must be predicted
    always @(negedge CLK) begin
        if (INSTR_VALID === 1'b1 && !prev_valid) begin
            if (sb.size() == 0) begin
                check("sb_unexpected", INSTRUCTION, 32'hx);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_instr", INSTRUCTION, e.instr);
                check("sb_pc", PC, e.pc);
            end
        end
        prev_valid = (INSTR_VALID === 1'b1);
    end

    task automatic fetch(input int busy);
        check("fetch_read", {31'd0, IMEM_READ}, 32'd1);
        check("fetch_addr", IMEM_ADDRESS, exp_pc);
        IMEM_BUSYWAIT = 1'b1;
        for (int i = 0; i < busy; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            check("bw_read", {31'd0, IMEM_READ}, 32'd1);
            check("bw_addr", IMEM_ADDRESS, exp_pc);
            check("bw_valid", {31'd0, INSTR_VALID}, 32'd0);
        end
        exp_instr = mem(exp_pc);
        sb.push_back('{pc: exp_pc, instr: exp_instr});
        IMEM_BUSYWAIT = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("fetch_valid", {31'd0, INSTR_VALID}, 32'd1);
        check("exec_read", {31'd0, IMEM_READ}, 32'd0);
    endtask

    task automatic retire(input logic j, input logic b, input logic z,
                          input logic [7:0] off, input int busy);
        logic [31:0] tgt;
        JUMP = j;
        BRANCH = b;
        ZERO = z;
        OFFSET = off;
        EXEC_BUSY = 1'b1;
        for (int i = 0; i < busy; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            check("hold_pc", PC, exp_pc);
            check("hold_instr", INSTRUCTION, exp_instr);
            check("hold_cnt", INSTR_COUNT, exp_cnt);
            check("hold_valid", {31'd0, INSTR_VALID}, 32'd1);
        end
        EXEC_BUSY = 1'b0;
        tgt = exp_pc + 32'd4;
        if (j || (b && z))
            tgt = tgt + {{22{off[7]}}, off, 2'b00};
        exp_pc = tgt;
        exp_cnt = exp_cnt + 32'd1;
        @(posedge CLK);
        @(negedge CLK);
        check("ret_pc", PC, exp_pc);
        check("ret_cnt", INSTR_COUNT, exp_cnt);
        check("ret_valid", {31'd0, INSTR_VALID}, 32'd0);
        check("ret_instr", INSTRUCTION, exp_instr);
        JUMP = 1'b0;
        BRANCH = 1'b0;
        ZERO = 1'b0;
        OFFSET = 8'h00;
    endtask

    task automatic check_reset_state();
        check("rst_pc", PC, 32'h0);
        check("rst_valid", {31'd0, INSTR_VALID}, 32'd0);
        check("rst_cnt", INSTR_COUNT, 32'h0);
        check("rst_read", {31'd0, IMEM_READ}, 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_reset_state();
        check("rst_instr", INSTRUCTION, 32'h0);
        RESET = 1'b0;
        #1;
        check("first_read", {31'd0, IMEM_READ}, 32'd1);
        check("first_addr", IMEM_ADDRESS, 32'h0);

        // zero-wait stream of three words
        for (int k = 0; k < 3; k++) begin
            fetch(0);
            retire(1'b0, 1'b0, 1'b0, 8'h00, 0);
        end
        check("cnt_three", INSTR_COUNT, 32'd3);
        check("pc_c", PC, 32'h0000_000C);

        fetch(0);
        retire(1'b0, 1'b0, 1'b0, 8'h00, 0);
        fetch(0);
        retire(1'b1, 1'b0, 1'b0, 8'hFE, 0);
        check("jump_back", PC, 32'h0000_000C);
        fetch(0);
        retire(1'b1, 1'b0, 1'b0, 8'h04, 0);
        check("at_20", PC, 32'h0000_0020);

        fetch(0);
        retire(1'b0, 1'b1, 1'b0, 8'h03, 0);
        check("br_nt", PC, 32'h0000_0024);
        fetch(0);
        retire(1'b1, 1'b0, 1'b0, 8'hFE, 0);
        fetch(0);
        retire(1'b0, 1'b1, 1'b1, 8'h03, 0);
        check("br_t", PC, 32'h0000_0030);
        fetch(0);
        retire(1'b1, 1'b0, 1'b0, 8'hFB, 0);
        fetch(0);
        retire(1'b1, 1'b1, 1'b0, 8'h03, 0);
        check("jmp_br", PC, 32'h0000_0030);

        fetch(0);
        retire(1'b1, 1'b0, 1'b0, 8'hF2, 0);
        check("at_top", PC, 32'hFFFF_FFFC);
        fetch(0);
        retire(1'b0, 1'b0, 1'b0, 8'h00, 0);
        check("wrap", PC, 32'h0000_0000);

        // busywait fetch at PC=4, then a stalled execute
        fetch(0);
        retire(1'b0, 1'b0, 1'b0, 8'h00, 0);
        fetch(3);
        retire(1'b0, 1'b0, 1'b0, 8'h00, 2);
        check("after_stall", PC, 32'h0000_0008);

        fetch(0);
        retire(1'b1, 1'b0, 1'b0, 8'h0D, 0);
        check("at_40", PC, 32'h0000_0040);

        // reset in the middle of a busywait fetch
        IMEM_BUSYWAIT = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("bw40_addr", IMEM_ADDRESS, 32'h0000_0040);
        RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check_reset_state();
        RESET = 1'b0;
        IMEM_BUSYWAIT = 1'b0;
        exp_pc = 32'h0;
        exp_cnt = 32'h0;
        #1;
        check("rel_read", {31'd0, IMEM_READ}, 32'd1);
        check("rel_addr", IMEM_ADDRESS, 32'h0);

        // reset wins over a retire in S_EXEC
        fetch(0);
        JUMP = 1'b1;
        OFFSET = 8'h05;
        RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check_reset_state();
        check("rst2_instr", INSTRUCTION, 32'h0);
        RESET = 1'b0;
        JUMP = 1'b0;
        OFFSET = 8'h00;
        #1;
        check("rel2_read", {31'd0, IMEM_READ}, 32'd1);
        check("rel2_addr", IMEM_ADDRESS, 32'h0);

        fetch(0);
        retire(1'b0, 1'b0, 1'b0, 8'h00, 0);
        check("final_cnt", INSTR_COUNT, 32'd1);
        check("sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
